fdtd_step_sequencer: RTL and testbench
======================================

Name: fdtd_step_sequencer

Overview:
- Autonomous multi-timestep controller for the 1-D FDTD accelerator.
- Each time step runs three phases with no per-phase CPU interaction: Hy sweep, Ez sweep, source injection.
- Each phase ends with a write-back handshake (ram buffer -> data mem) to the memory controller.
- Cell count, step count and source cell are set at run time; datapath pipeline latencies are compile-time parameters.

Parameters:
ADDR_W, 6, buffer address width; max cells 2^ADDR_W
STEP_W, 16, width of step count and step counter
HY_LAT, 4, cycles from Hy-phase read enable to matching write enable (1..15)
EZ_LAT, 4, cycles from Ez-phase read enable to matching write enable (1..15)
SRC_LAT, 2, cycles from source read enable to source write enable (1..15)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
start_i  in  1  run request; sampled only in IDLE
abort_i  in  1  synchronous abort, any state
num_cells_i  in  ADDR_W  cells N; latched on accepted start
num_steps_i  in  STEP_W  time steps S; latched on accepted start
src_addr_i  in  ADDR_W  source cell; latched on accepted start
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse on run completion
step_cnt_o  out  STEP_W  completed steps in current run
rd_hy_en_o / rd_hy_addr_o  out  1 / ADDR_W  Hy old-value read port
rd_ez_en_o / rd_ez_addr_o  out  1 / ADDR_W  Ez old-value read port
wr_hy_en_o / wr_hy_addr_o  out  1 / ADDR_W  Hy new-value write port
wr_ez_en_o / wr_ez_addr_o  out  1 / ADDR_W  Ez new-value write port
calc_mode_o  out  2  datapath select: 0 none, 1 Hy, 2 Ez, 3 src
wb_start_o  out  1  one-cycle write-back request
wb_sel_o  out  2  buffer to write back: 1 Hy, 2 Ez, 3 src
wb_done_i  in  1  write-back complete pulse from memory controller
cycle_cnt_o  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; step counter, index counter and delay lines cleared.
- States: IDLE, HY_RUN, HY_DRAIN, HY_WB, EZ_RUN, EZ_DRAIN, EZ_WB, SRC_RUN, SRC_DRAIN, SRC_WB, DONE.
- IDLE -> HY_RUN on start_i.
- Degenerate start: if N==0 or S==0, go IDLE -> DONE. No memory access occurs.
- HY_RUN, N cycles, index k=0..N-1:
  - rd_hy_en=1, rd_hy_addr=k.
  - rd_ez_en=1, rd_ez_addr=min(k+1,N-1).
  - At k==N-1, go to HY_DRAIN.
- EZ_RUN, N cycles:
  - rd_ez_addr=k.
  - rd_hy_addr=max(k-1,0).
- SRC_RUN, 1 cycle: rd_ez_en=1, rd_ez_addr=src.
- Write timing: each read issue is pushed into a per-phase delay line.
  - wr_*_en is asserted exactly LAT cycles after the read issue for index k.
  - wr_*_addr equals k (src for the source phase).
  - Hy writes on wr_hy_*; Ez and source writes on wr_ez_*.
- *_DRAIN: held until the last write has been issued, then go to *_WB. Total phase length is N+LAT cycles (SRC: 1+SRC_LAT).
- calc_mode_o holds the phase value through RUN and DRAIN; 0 otherwise.
- *_WB:
  - On entry, wb_start_o pulses for 1 cycle; wb_sel_o holds the phase code until wb_done_i.
  - wb_done_i advances the state: HY_WB -> EZ_RUN, EZ_WB -> SRC_RUN.
  - SRC_WB increments step_cnt_o; if the new count == S, go to DONE, else go to HY_RUN.
  - wb_done_i outside a WB state is ignored.
- DONE: done_o=1 for one cycle, then IDLE. step_cnt_o holds until the next accepted start, which clears it.
- abort_i: next state is IDLE.
  - All enables, wb_start_o and the delay lines clear on the same edge.
  - Writes in flight are dropped and done_o is not pulsed.
  - abort_i has priority over start_i and wb_done_i.
- Address arithmetic is unsigned ADDR_W bits.
- Run-time inputs are ignored while busy.

Optional Feature:
- Macro: FDTD_PERF_CNT_EN.
- Defined: cycle_cnt_o clears on an accepted start and increments every cycle while busy_o=1. It saturates at 32'hFFFF_FFFF and holds after done/abort.
- Undefined: cycle_cnt_o is tied to 0 and no counter logic is present. The port list is unchanged.

Test Plan:
1. N=50, S=1, src=10, wb_done_i returned 3 cycles after each wb_start_o:
   - rd_hy_en high 50 cycles, addresses 0..49; rd_ez_addr 1..49,49.
   - wr_hy_en high 50 cycles starting 4 cycles after the first read.
   - Ez phase follows; one src write to addr 10; step_cnt_o=1; done_o single pulse.
2. N=8, S=3:
   - Exactly 3 Hy/Ez/src sequences and 9 wb_start_o pulses with wb_sel 1,2,3 repeating.
   - done_o after the third SRC_WB; with FDTD_PERF_CNT_EN, cycle_cnt_o equals the measured busy cycles.
3. N=0 or S=0 with start_i: busy_o high 1 cycle (DONE), done_o pulse, no rd/wr enable ever asserted.
4. abort_i mid EZ_RUN (k=20, N=50): next cycle IDLE, all enables 0, no further writes, no done_o; a fresh start then runs normally.
5. wb_done_i held low 100 cycles in HY_WB: FSM waits, wb_start_o not re-pulsed, no reads issued. Stray wb_done_i during HY_RUN has no effect.
6. RST_N asserted mid-run: all outputs 0 immediately (asynchronous); after release, IDLE, ready for start_i.

Source files
------------

// File: rtl/fdtd_step_sequencer.sv
// Multi-timestep sequencer for the 1-D FDTD engine: Hy sweep, Ez sweep, source injection, each closed by a write-back.
// Optional busy-cycle counter: compile with `define FDTD_PERF_CNT_EN.
module fdtd_step_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int STEP_W  = 16,
  parameter int HY_LAT  = 4,
  parameter int EZ_LAT  = 4,
  parameter int SRC_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] num_cells_i,
  input  logic [STEP_W-1:0] num_steps_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_cnt_o,
  output logic              rd_hy_en_o,
  output logic [ADDR_W-1:0] rd_hy_addr_o,
  output logic              rd_ez_en_o,
  output logic [ADDR_W-1:0] rd_ez_addr_o,
  output logic              wr_hy_en_o,
  output logic [ADDR_W-1:0] wr_hy_addr_o,
  output logic              wr_ez_en_o,
  output logic [ADDR_W-1:0] wr_ez_addr_o,
  output logic [1:0]        calc_mode_o,
  output logic              wb_start_o,
  output logic [1:0]        wb_sel_o,
  input  logic              wb_done_i,
  output logic [31:0]       cycle_cnt_o
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_HY_RUN    = 4'd1;
  localparam logic [3:0] S_HY_DRAIN  = 4'd2;
  localparam logic [3:0] S_HY_WB     = 4'd3;
  localparam logic [3:0] S_EZ_RUN    = 4'd4;
  localparam logic [3:0] S_EZ_DRAIN  = 4'd5;
  localparam logic [3:0] S_EZ_WB     = 4'd6;
  localparam logic [3:0] S_SRC_RUN   = 4'd7;
  localparam logic [3:0] S_SRC_DRAIN = 4'd8;
  localparam logic [3:0] S_SRC_WB    = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  localparam logic [3:0] HY_LAST  = 4'(HY_LAT - 1);
  localparam logic [3:0] EZ_LAST  = 4'(EZ_LAT - 1);
  localparam logic [3:0] SRC_LAST = 4'(SRC_LAT - 1);

  logic [3:0]        state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [3:0]        drain_reg, drain_next;
  logic [STEP_W-1:0] step_cnt_reg, step_cnt_next;
  logic [ADDR_W-1:0] cells_reg, src_reg;
  logic [STEP_W-1:0] steps_reg;
  logic              wb_start_reg;
  logic              start_acc;
  logic [ADDR_W-1:0] last_idx;

  assign last_idx = cells_reg - ADDR_W'(1);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    drain_next    = drain_reg;
    step_cnt_next = step_cnt_reg;
    start_acc     = 1'b0;
    if (abort_i) begin
      state_next = S_IDLE;
      idx_next   = '0;
      drain_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start_i) begin
          start_acc     = 1'b1;
          step_cnt_next = '0;
          idx_next      = '0;
          drain_next    = '0;
          state_next    = (num_cells_i == '0 || num_steps_i == '0) ? S_DONE : S_HY_RUN;
        end
        S_HY_RUN, S_EZ_RUN: begin
          if (idx_reg == last_idx) begin
            idx_next   = '0;
            state_next = (state_reg == S_HY_RUN) ? S_HY_DRAIN : S_EZ_DRAIN;
          end else begin
            idx_next = idx_reg + ADDR_W'(1);
          end
        end
        S_SRC_RUN: state_next = S_SRC_DRAIN;
        // Drain length equals the phase latency so the last write lands in the final drain cycle.
        S_HY_DRAIN, S_EZ_DRAIN, S_SRC_DRAIN: begin
          if ((state_reg == S_HY_DRAIN && drain_reg == HY_LAST) ||
              (state_reg == S_EZ_DRAIN && drain_reg == EZ_LAST) ||
              (state_reg == S_SRC_DRAIN && drain_reg == SRC_LAST)) begin
            drain_next = '0;
            state_next = (state_reg == S_HY_DRAIN) ? S_HY_WB :
                         (state_reg == S_EZ_DRAIN) ? S_EZ_WB : S_SRC_WB;
          end else begin
            drain_next = drain_reg + 4'd1;
          end
        end
        S_HY_WB: if (wb_done_i) state_next = S_EZ_RUN;
        S_EZ_WB: if (wb_done_i) state_next = S_SRC_RUN;
        S_SRC_WB: if (wb_done_i) begin
          step_cnt_next = step_cnt_reg + STEP_W'(1);
          state_next    = (step_cnt_reg + STEP_W'(1) == steps_reg) ? S_DONE : S_HY_RUN;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      drain_reg    <= '0;
      step_cnt_reg <= '0;
      cells_reg    <= '0;
      steps_reg    <= '0;
      src_reg      <= '0;
      wb_start_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      drain_reg    <= drain_next;
      step_cnt_reg <= step_cnt_next;
      wb_start_reg <= (state_next != state_reg) &&
                      (state_next == S_HY_WB || state_next == S_EZ_WB || state_next == S_SRC_WB);
      if (start_acc) begin
        cells_reg <= num_cells_i;
        steps_reg <= num_steps_i;
        src_reg   <= src_addr_i;
      end
    end
  end

  // Per-phase delay lines: {valid, index}; index is zero whenever valid is low.
  logic [ADDR_W:0] hy_push, ez_push;
  logic            src_push;
  logic [ADDR_W:0] hy_dly_reg [HY_LAT];
  logic [ADDR_W:0] hy_dly_in  [HY_LAT];
  logic [ADDR_W:0] ez_dly_reg [EZ_LAT];
  logic [ADDR_W:0] ez_dly_in  [EZ_LAT];
  logic            src_dly_reg [SRC_LAT];
  logic            src_dly_in  [SRC_LAT];

  assign hy_push  = {state_reg == S_HY_RUN, (state_reg == S_HY_RUN) ? idx_reg : '0};
  assign ez_push  = {state_reg == S_EZ_RUN, (state_reg == S_EZ_RUN) ? idx_reg : '0};
  assign src_push = (state_reg == S_SRC_RUN);

  for (genvar gi = 0; gi < HY_LAT; gi++) begin : g_hy_dly
    if (gi == 0) begin : g_head
      assign hy_dly_in[gi] = hy_push;
    end else begin : g_tail
      assign hy_dly_in[gi] = hy_dly_reg[gi-1];
    end
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) hy_dly_reg[gi] <= '0;
      else        hy_dly_reg[gi] <= abort_i ? '0 : hy_dly_in[gi];
    end
  end

  for (genvar gi = 0; gi < EZ_LAT; gi++) begin : g_ez_dly
    if (gi == 0) begin : g_head
      assign ez_dly_in[gi] = ez_push;
    end else begin : g_tail
      assign ez_dly_in[gi] = ez_dly_reg[gi-1];
    end
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) ez_dly_reg[gi] <= '0;
      else        ez_dly_reg[gi] <= abort_i ? '0 : ez_dly_in[gi];
    end
  end

  for (genvar gi = 0; gi < SRC_LAT; gi++) begin : g_src_dly
    if (gi == 0) begin : g_head
      assign src_dly_in[gi] = src_push;
    end else begin : g_tail
      assign src_dly_in[gi] = src_dly_reg[gi-1];
    end
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) src_dly_reg[gi] <= 1'b0;
      else        src_dly_reg[gi] <= abort_i ? 1'b0 : src_dly_in[gi];
    end
  end

  assign wr_hy_en_o   = hy_dly_reg[HY_LAT-1][ADDR_W];
  assign wr_hy_addr_o = hy_dly_reg[HY_LAT-1][ADDR_W-1:0];
  assign wr_ez_en_o   = ez_dly_reg[EZ_LAT-1][ADDR_W] | src_dly_reg[SRC_LAT-1];
  assign wr_ez_addr_o = ez_dly_reg[EZ_LAT-1][ADDR_W-1:0] | (src_dly_reg[SRC_LAT-1] ? src_reg : '0);

  always_comb begin
    rd_hy_en_o   = 1'b0;
    rd_hy_addr_o = '0;
    rd_ez_en_o   = 1'b0;
    rd_ez_addr_o = '0;
    calc_mode_o  = 2'd0;
    wb_sel_o     = 2'd0;
    case (state_reg)
      S_HY_RUN: begin
        rd_hy_en_o   = 1'b1;
        rd_hy_addr_o = idx_reg;
        rd_ez_en_o   = 1'b1;
        rd_ez_addr_o = (idx_reg == last_idx) ? idx_reg : idx_reg + ADDR_W'(1);
        calc_mode_o  = 2'd1;
      end
      S_HY_DRAIN: calc_mode_o = 2'd1;
      S_HY_WB:    wb_sel_o = 2'd1;
      S_EZ_RUN: begin
        rd_ez_en_o   = 1'b1;
        rd_ez_addr_o = idx_reg;
        rd_hy_en_o   = 1'b1;
        rd_hy_addr_o = (idx_reg == '0) ? '0 : idx_reg - ADDR_W'(1);
        calc_mode_o  = 2'd2;
      end
      S_EZ_DRAIN: calc_mode_o = 2'd2;
      S_EZ_WB:    wb_sel_o = 2'd2;
      S_SRC_RUN: begin
        rd_ez_en_o   = 1'b1;
        rd_ez_addr_o = src_reg;
        calc_mode_o  = 2'd3;
      end
      S_SRC_DRAIN: calc_mode_o = 2'd3;
      S_SRC_WB:    wb_sel_o = 2'd3;
      default: ;
    endcase
  end

  assign busy_o     = (state_reg != S_IDLE);
  assign done_o     = (state_reg == S_DONE);
  assign step_cnt_o = step_cnt_reg;
  assign wb_start_o = wb_start_reg;

`ifdef FDTD_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                          cycle_cnt_reg <= '0;
    else if (start_acc)                                  cycle_cnt_reg <= '0;
    else if (busy_o && cycle_cnt_reg != 32'hFFFF_FFFF)   cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
  end
  assign cycle_cnt_o = cycle_cnt_reg;
`else
  assign cycle_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_fdtd_step_sequencer.sv
// Scoreboard bench for fdtd_step_sequencer: expected read/write/write-back/done events are queued per run and
// popped by a negedge monitor whenever the sequencer presents one.
module tb_fdtd_step_sequencer;
  localparam int AW = 6, SW = 16, HL = 4, EL = 4, SL = 2;
  localparam int BIG = 1000000;

  logic          CLK = 1'b0, RST_N = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0;
  logic [AW-1:0] num_cells_i = '0, src_addr_i = '0;
  logic [SW-1:0] num_steps_i = '0;
  logic          busy_o, done_o, rd_hy_en_o, rd_ez_en_o, wr_hy_en_o, wr_ez_en_o, wb_start_o, wb_done_i;
  logic [SW-1:0] step_cnt_o;
  logic [AW-1:0] rd_hy_addr_o, rd_ez_addr_o, wr_hy_addr_o, wr_ez_addr_o;
  logic [1:0]    calc_mode_o, wb_sel_o;
  logic [31:0]   cycle_cnt_o;
  logic          resp_wb = 1'b0, stray_wb = 1'b0;

  assign wb_done_i = resp_wb | stray_wb;

  fdtd_step_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .start_i(start_i), .abort_i(abort_i),
    .num_cells_i(num_cells_i), .num_steps_i(num_steps_i), .src_addr_i(src_addr_i),
    .busy_o(busy_o), .done_o(done_o), .step_cnt_o(step_cnt_o),
    .rd_hy_en_o(rd_hy_en_o), .rd_hy_addr_o(rd_hy_addr_o),
    .rd_ez_en_o(rd_ez_en_o), .rd_ez_addr_o(rd_ez_addr_o),
    .wr_hy_en_o(wr_hy_en_o), .wr_hy_addr_o(wr_hy_addr_o),
    .wr_ez_en_o(wr_ez_en_o), .wr_ez_addr_o(wr_ez_addr_o),
    .calc_mode_o(calc_mode_o), .wb_start_o(wb_start_o), .wb_sel_o(wb_sel_o),
    .wb_done_i(wb_done_i), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]  kind;   // 1 read, 2 Hy write, 3 Ez write, 4 wb_start, 5 done
    logic [15:0] val;
  } ev_t;

  ev_t sb_q[$];
  int  neg_cnt = 0, n_tests = 0, n_fail = 0, wb_delay = 3;

  function automatic void push(input int cyc, input int kind, input int val);
    ev_t e;
    e.cyc  = cyc;
    e.kind = 3'(kind);
    e.val  = 16'(val);
    sb_q.push_back(e);
  endfunction

  // Read event word: {calc_mode, hy_en, hy_addr, ez_en, ez_addr}
  function automatic int rdw(input int mode, input int hen, input int ha, input int een, input int ea);
    logic [15:0] w;
    w = {2'(mode), 1'(hen), 6'(ha), 1'(een), 6'(ea)};
    return int'(w);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic expect_pop(input int kind, input logic [15:0] val);
    ev_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event cyc=%0d kind=%0d got=%h required=none", neg_cnt, kind, val);
    end else begin
      e = sb_q.pop_front();
      if (e.cyc != neg_cnt || e.kind != 3'(kind) || e.val != val) begin
        n_fail++;
        $display("FAIL event cyc got=%0d required=%0d kind got=%0d required=%0d val got=%h required=%h",
                 neg_cnt, e.cyc, kind, e.kind, val, e.val);
      end
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge CLK);
    neg_cnt++;
    if (rd_hy_en_o || rd_ez_en_o)
      expect_pop(1, {calc_mode_o, rd_hy_en_o, rd_hy_en_o ? rd_hy_addr_o : 6'd0,
                     rd_ez_en_o, rd_ez_en_o ? rd_ez_addr_o : 6'd0});
    if (wr_hy_en_o) expect_pop(2, 16'(wr_hy_addr_o));
    if (wr_ez_en_o) expect_pop(3, 16'(wr_ez_addr_o));
    if (wb_start_o) expect_pop(4, 16'(wb_sel_o));
    if (done_o)     expect_pop(5, step_cnt_o);
  end

  // Memory-controller responder: wb_done in the wb_delay-th cycle after wb_start.
  initial forever begin
    @(negedge CLK);
    if (wb_start_o) begin
      repeat (wb_delay) @(posedge CLK);
      #1 resp_wb = 1'b1;
      @(posedge CLK);
      #1 resp_wb = 1'b0;
    end
  end

  // Expected events of one run, cycle t relative to the first busy cycle; events after 'cut' are not issued.
  task automatic gen_run(input int base, input int n, input int s, input int src, input int cut, output int total);
    int wb, l, e0, r0, u;
    wb = wb_delay + 1;
    if (n == 0 || s == 0) begin
      push(base, 5, 0);
      total = 1;
      return;
    end
    e0 = n + HL + wb;
    r0 = e0 + n + EL + wb;
    l  = r0 + 1 + SL + wb;
    total = s * l + 1;
    for (int t = 0; t < total && t <= cut; t++) begin
      u = t % l;
      if (t == s * l) begin
        push(base + t, 5, s);
      end else begin
        if (u < n)                        push(base + t, 1, rdw(1, 1, u, 1, (u + 1 < n) ? u + 1 : n - 1));
        else if (u >= e0 && u < e0 + n)   push(base + t, 1, rdw(2, 1, (u > e0) ? u - e0 - 1 : 0, 1, u - e0));
        else if (u == r0)                 push(base + t, 1, rdw(3, 0, 0, 1, src));
        if (u >= HL && u < HL + n)        push(base + t, 2, u - HL);
        if (u >= e0 + EL && u < e0 + EL + n) push(base + t, 3, u - e0 - EL);
        if (u == r0 + SL)                 push(base + t, 3, src);
        if (u == n + HL)                  push(base + t, 4, 1);
        if (u == e0 + n + EL)             push(base + t, 4, 2);
        if (u == r0 + 1 + SL)             push(base + t, 4, 3);
      end
    end
  endtask

  task automatic do_start(input int n, input int s, input int src, output int base);
    @(posedge CLK);
    #1;
    num_cells_i = AW'(n);
    num_steps_i = SW'(s);
    src_addr_i  = AW'(src);
    start_i     = 1'b1;
    @(posedge CLK);
    #1;
    start_i = 1'b0;
    base    = neg_cnt + 1;
    num_cells_i = 6'd63;   // must be ignored while busy
    num_steps_i = 16'd7;
    src_addr_i  = 6'd33;
    $display("[TB] run N=%0d S=%0d src=%0d wb_delay=%0d", n, s, src, wb_delay);
  endtask

  task automatic run(input int n, input int s, input int src);
    int base, total;
    do_start(n, s, src, base);
    gen_run(base, n, s, src, BIG, total);
    repeat (total + 3) @(posedge CLK);
    #1 chk("sb_drained", 64'(sb_q.size()), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_rd_en"}, {rd_hy_en_o, rd_ez_en_o}, 0);
    chk({tag, "_wr_en"}, {wr_hy_en_o, wr_ez_en_o}, 0);
    chk({tag, "_wb_start"}, wb_start_o, 0);
    chk({tag, "_calc_mode"}, calc_mode_o, 0);
  endtask

  initial begin
    int base, total;
    #2;
    chk_quiet("reset");
    chk("reset_step_cnt", step_cnt_o, 0);
    chk("reset_wb_sel", wb_sel_o, 0);
    chk("reset_cycle_cnt", cycle_cnt_o, 0);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // 1: single step, long grid
    run(50, 1, 10);
    chk("t1_step_cnt", step_cnt_o, 1);
    chk("t1_busy", busy_o, 0);

    // 2: three steps; busy cycles = 3*(2*8+23)+1 = 118
    run(8, 3, 5);
    chk("t2_step_cnt", step_cnt_o, 3);
`ifdef FDTD_PERF_CNT_EN
    chk("t2_cycle_cnt", cycle_cnt_o, 118);
`else
    chk("t2_cycle_cnt", cycle_cnt_o, 0);
`endif

    // 3: degenerate starts
    do_start(0, 4, 1, base);
    chk("t3a_busy", busy_o, 1);
    gen_run(base, 0, 4, 1, BIG, total);
    @(posedge CLK);
    #1 chk("t3a_idle", busy_o, 0);
    do_start(5, 0, 1, base);
    chk("t3b_busy", busy_o, 1);
    gen_run(base, 5, 0, 1, BIG, total);
    @(posedge CLK);
    #1 chk("t3b_idle", busy_o, 0);
    chk("t3b_step_cnt", step_cnt_o, 0);
    repeat (3) @(posedge CLK);
    #1 chk("t3_sb_drained", 64'(sb_q.size()), 0);

    // 4: abort at Ez k=20 (cycle 58+20), then a fresh run
    do_start(50, 1, 3, base);
    gen_run(base, 50, 1, 3, 78, total);
    repeat (78) @(posedge CLK);
    #1 abort_i = 1'b1;
    @(posedge CLK);
    #1 abort_i = 1'b0;
    chk_quiet("t4_abort");
    repeat (60) @(posedge CLK);
    #1 chk("t4_sb_drained", 64'(sb_q.size()), 0);
    run(4, 1, 2);

    // 5: slow write-back plus a stray wb_done during HY_RUN
    wb_delay = 100;
    do_start(4, 1, 1, base);
    gen_run(base, 4, 1, 1, BIG, total);
    repeat (2) @(posedge CLK);
    #1 stray_wb = 1'b1;
    @(posedge CLK);
    #1 stray_wb = 1'b0;
    repeat (50) @(posedge CLK);
    #1 chk("t5_wb_sel_hold", wb_sel_o, 1);
    chk("t5_wb_start_low", wb_start_o, 0);
    chk("t5_busy", busy_o, 1);
    repeat (total) @(posedge CLK);
    #1 chk("t5_sb_drained", 64'(sb_q.size()), 0);
    wb_delay = 3;

    // 6: asynchronous reset in the second step (cycle 45 of N=8,S=2)
    do_start(8, 2, 6, base);
    gen_run(base, 8, 2, 6, BIG, total);
    repeat (45) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    chk_quiet("t6_reset");
    chk("t6_step_cnt", step_cnt_o, 0);
    sb_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    #1 chk("t6_idle", busy_o, 0);
    run(3, 1, 2);
    chk("t6_step_cnt_after", step_cnt_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
